// File: rtl/multicycle_control.sv
// Multicycle sequencer for the ARM-subset datapath: Moore FSM, NZCV flags, condition check.
// Optional MC_CTRL_PERF_EN adds cycle_count / instr_count performance counters.
module multicycle_control #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rd,
  input  logic [3:0]  cond,
  input  logic [3:0]  alu_flags,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic        reg_write,
  output logic        undef,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
`endif
  output logic [3:0]  flags
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXER   = 4'd6, S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8, S_BRANCH = 4'd9
  } state_t;

  state_t state, next;

  logic [3:0] cmd;
  logic       s_bit, is_cmp, bad_cmd, nowrite, arith, cond_ex, flag_upd;
  logic [1:0] alu_op;
  logic       pc_write_d, mem_write_d, ir_write_d, reg_write_d, undef_d;
  logic       n_f, z_f, c_f, v_f;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    alu_op  = 2'b00;
    nowrite = 1'b0;
    bad_cmd = 1'b0;
    arith   = 1'b0;
    is_cmp  = 1'b0;
    case (cmd)
      4'b0100: begin alu_op = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_op = 2'b01; arith = 1'b1; end
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      4'b1010: begin alu_op = 2'b01; arith = 1'b1; nowrite = 1'b1; is_cmp = 1'b1; end
      default: begin nowrite = 1'b1; bad_cmd = 1'b1; end
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = z_f;
      4'h1: cond_ex = ~z_f;
      4'h2: cond_ex = c_f;
      4'h3: cond_ex = ~c_f;
      4'h4: cond_ex = n_f;
      4'h5: cond_ex = ~n_f;
      4'h6: cond_ex = v_f;
      4'h7: cond_ex = ~v_f;
      4'h8: cond_ex = c_f & ~z_f;
      4'h9: cond_ex = ~c_f | z_f;
      4'hA: cond_ex = (n_f == v_f);
      4'hB: cond_ex = (n_f != v_f);
      4'hC: cond_ex = ~z_f & (n_f == v_f);
      4'hD: cond_ex = z_f | (n_f != v_f);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // CMP always updates flags; unsupported commands never do.
  assign flag_upd = cond_ex & (s_bit | is_cmp) & ~bad_cmd;

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = S_DECODE;
      S_DECODE: case (op)
                  2'b01:   next = S_MEMADR;
                  2'b00:   next = funct[5] ? S_EXEI : S_EXER;
                  2'b10:   next = S_BRANCH;
                  default: next = S_FETCH;
                endcase
      S_MEMADR: next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = S_MEMWB;
      S_EXER:   next = S_ALUWB;
      S_EXEI:   next = S_ALUWB;
      default:  next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      flags <= FLAGS_INIT;
    end else begin
      state <= next;
      if ((state == S_EXER || state == S_EXEI) && flag_upd) begin
        flags[3:2] <= alu_flags[3:2];
        if (arith) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (state != S_FETCH && next == S_FETCH) instr_count <= instr_count + 32'd1;
    end
  end
`endif

  always_comb begin
    pc_write_d  = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    undef_d     = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_d = 1'b1;
        pc_write_d = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        undef_d    = (op == 2'b11);
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_d = cond_ex;
        pc_write_d  = cond_ex & (rd == 4'd15);
      end
      S_MEMWR: begin
        adr_src     = 1'b1;
        mem_write_d = cond_ex;
      end
      S_EXER, S_EXEI: begin
        alu_src_b   = (state == S_EXEI) ? 2'b01 : 2'b00;
        alu_control = alu_op;
        undef_d     = bad_cmd;
      end
      S_ALUWB: begin
        reg_write_d = cond_ex & ~nowrite;
        pc_write_d  = cond_ex & ~nowrite & (rd == 4'd15);
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write_d = cond_ex;
      end
      default: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
    endcase
  end

  // Strobes are suppressed the instant reset asserts, independent of the clock.
  assign pc_write  = pc_write_d  & rst_n;
  assign mem_write = mem_write_d & rst_n;
  assign ir_write  = ir_write_d  & rst_n;
  assign reg_write = reg_write_d & rst_n;
  assign undef     = undef_d     & rst_n;
  assign imm_src   = op;
  assign reg_src   = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control; expected cycles come from a
// phase-list model of each instruction class.
module tb_multicycle_control;
  logic       clk = 1'b0, rst_n = 1'b1;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'd0;
  logic [3:0] rd = 4'd0, cond = 4'hE, alu_flags = 4'd0;
  logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write, undef;
  logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0] flags;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_control #(.FLAGS_INIT(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_src(reg_src), .reg_write(reg_write), .undef(undef),
`ifdef MC_CTRL_PERF_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .flags(flags)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  logic [3:0] mflags = 4'b0000;
  logic [20:0] act;
  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                alu_control, reg_write, undef, imm_src, reg_src, flags};

  function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {unsupported, nowrite, arithmetic (C/V update), alu_control}
  function automatic logic [4:0] alu_info(input logic [3:0] c);
    case (c)
      4'b0100: return 5'b001_00;
      4'b0010: return 5'b001_01;
      4'b0000: return 5'b000_10;
      4'b1100: return 5'b000_11;
      4'b1010: return 5'b011_01;
      default: return 5'b110_00;
    endcase
  endfunction

  function automatic logic [20:0] expect_out(input byte ph, input logic c, input logic [1:0] o,
                                             input logic [5:0] f, input logic [3:0] r,
                                             input logic [3:0] fl);
    logic pcw, adr, mw, irw, a, rw, ud, bad, nw, ar;
    logic [1:0] rs, b, ctl, actl;
    {pcw, adr, mw, irw, a, rw, ud} = 7'd0;
    rs = 2'b00; b = 2'b00; ctl = 2'b00;
    {bad, nw, ar, actl} = alu_info(f[4:1]);
    case (ph)
      "F": begin a = 1; b = 2'b10; rs = 2'b10; irw = 1; pcw = 1; end
      "D": begin a = 1; b = 2'b10; rs = 2'b10; ud = (o == 2'b11); end
      "A": b = 2'b01;
      "R": adr = 1;
      "W": begin rs = 2'b01; rw = c; pcw = c && (r == 15); end
      "S": begin adr = 1; mw = c; end
      "X": begin b = 2'b00; ctl = actl; ud = bad; end
      "I": begin b = 2'b01; ctl = actl; ud = bad; end
      "L": begin rw = c && !nw; pcw = c && !nw && (r == 15); end
      "B": begin b = 2'b01; rs = 2'b10; pcw = c; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, a, b, ctl, rw, ud, o, o == 2'b01, o == 2'b10, fl};
  endfunction

  // Entered and left just after a rising edge, at the start of a FETCH cycle.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] c, input logic [3:0] af, input string name);
    byte ph[$];
    logic [20:0] e;
    logic bad, nw, ar;
    logic [1:0] actl;
    ph = '{"F", "D"};
    case (o)
      2'b01: begin ph.push_back("A"); if (f[0]) begin ph.push_back("R"); ph.push_back("W"); end
                                      else ph.push_back("S"); end
      2'b00: begin ph.push_back(f[5] ? "I" : "X"); ph.push_back("L"); end
      2'b10: ph.push_back("B");
      default: ;
    endcase
    op = o; funct = f; rd = r; cond = c; alu_flags = af;
    foreach (ph[i]) begin
      @(negedge clk);
      e = expect_out(ph[i], cond_ok(mflags, c), o, f, r, mflags);
      vectors++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cycle %0d phase %c: got %b want %b", name, i, ph[i], act, e);
      end
      @(posedge clk); #1;
      if (ph[i] == "X" || ph[i] == "I") begin
        {bad, nw, ar, actl} = alu_info(f[4:1]);
        if (!bad && (f[0] || f[4:1] == 4'b1010) && cond_ok(mflags, c)) begin
          mflags[3:2] = af[3:2];
          if (ar) mflags[1:0] = af[1:0];
        end
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({pc_write, ir_write, mem_write, reg_write, undef, adr_src, alu_src_a, alu_src_b,
         result_src, flags} !== {5'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000}) begin
      errors++;
      $display("FAIL reset_hold: got strobes %b%b%b%b%b flags %b, want 00000 flags 0000",
               pc_write, ir_write, mem_write, reg_write, undef, flags);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    mflags = 4'b0000;
  endtask

  task automatic test_reset_mid;
    op = 2'b01; funct = 6'b011000; rd = 4'd2; cond = 4'hE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_memwr: mem_write got %b want 1", mem_write);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pc_write, ir_write, mem_write, reg_write, undef, adr_src, alu_src_a, alu_src_b,
         result_src, flags} !== {5'b0, 1'b0, 1'b1, 2'b10, 2'b10, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid_async: got strobes %b%b%b%b%b adr %b flags %b, want 00000 adr 0 flags 0000",
               pc_write, ir_write, mem_write, reg_write, undef, adr_src, flags);
    end
    mflags = 4'b0000;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_add_s;
    run_instr(2'b00, 6'b001001, 4'd3, 4'hE, 4'b0110, "add_s");
  endtask

  task automatic test_cmp_beq;
    run_instr(2'b00, 6'b010101, 4'd0, 4'hE, 4'b0100, "cmp");
    run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, "beq");
  endtask

  task automatic test_ldr;
    run_instr(2'b01, 6'b011001, 4'd5, 4'h1, 4'b1111, "ldr_ne");
    run_instr(2'b01, 6'b011001, 4'd15, 4'hE, 4'b0000, "ldr_pc");
  endtask

  task automatic test_str;
    run_instr(2'b01, 6'b011000, 4'd7, 4'hE, 4'b0000, "str");
  endtask

  task automatic test_undef;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cc0, ic0;
    cc0 = cycle_count; ic0 = instr_count;
`endif
    run_instr(2'b11, 6'b000000, 4'd0, 4'hE, 4'b0000, "undef");
`ifdef MC_CTRL_PERF_EN
    vectors++;
    if (cycle_count - cc0 !== 32'd2 || instr_count - ic0 !== 32'd1) begin
      errors++;
      $display("FAIL perf_undef: cycles +%0d instr +%0d, want +2 +1",
               cycle_count - cc0, instr_count - ic0);
    end
`endif
    run_instr(2'b00, 6'b011111, 4'd15, 4'hE, 4'b1111, "bad_cmd");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      run_instr(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), "random");
  endtask

  initial begin
    test_reset;
    test_add_s;
    test_reset_mid;
    test_cmp_beq;
    test_ldr;
    test_str;
    test_undef;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
